// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mem_port_arbiter_pkg                                             |
// | Brief   : Shared widths and FSM encoding for the unified memory arbiter.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package mem_port_arbiter_pkg;

    localparam int unsigned c_ADDR_W = 32;
    localparam int unsigned c_DATA_W = 32;
    localparam int unsigned c_MASK_W = c_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        I_ACT   = 2'd1,
        D_ACT   = 2'd2,
        I_DRAIN = 2'd3
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_resp_hold.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mem_port_arbiter_resp_hold                                       |
// | Brief   : Completed-response flag plus data register, held until cleared.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_port_arbiter_resp_hold
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = c_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_set,
    input  logic              i_cap,
    input  logic              i_clr,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_have,
    output logic [DATA_W-1:0] o_data
);

    logic              have_d;
    logic              have_q;
    logic [DATA_W-1:0] data_d;
    logic [DATA_W-1:0] data_q;

    // Clear beats set so a flush coinciding with a completion discards it.
    always_comb begin
        have_d = have_q;
        data_d = data_q;
        if (i_cap) begin
            data_d = i_data;
        end
        if (i_clr) begin
            have_d = 1'b0;
        end else if (i_set) begin
            have_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            have_q <= 1'b0;
            data_q <= '0;
        end else begin
            have_q <= have_d;
            data_q <= data_d;
        end
    end

    assign o_have = have_q;
    assign o_data = data_q;

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mem_port_arbiter                                                 |
// | Brief   : Shares one memory port between fetch and data requesters.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = c_ADDR_W,
    parameter int unsigned DATA_W = c_DATA_W,
    parameter int unsigned MASK_W = c_MASK_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              imem_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [MASK_W-1:0] d_wmask,
    output logic [DATA_W-1:0] d_rdata,
    output logic              dmem_stall,
    input  logic              flush,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic [MASK_W-1:0] m_wmask,
    input  logic              m_ready,
    input  logic [DATA_W-1:0] m_rdata
);

    arb_state_e        state_d;
    arb_state_e        state_q;
    logic              m_we_d;
    logic              m_we_q;
    logic [ADDR_W-1:0] m_addr_d;
    logic [ADDR_W-1:0] m_addr_q;
    logic [DATA_W-1:0] m_wdata_d;
    logic [DATA_W-1:0] m_wdata_q;
    logic [MASK_W-1:0] m_wmask_d;
    logic [MASK_W-1:0] m_wmask_q;

    logic              i_have;
    logic              d_have;
    logic              advance;
    logic              i_set;
    logic              i_cap;
    logic              d_set;
    logic              d_cap;

    assign imem_stall = i_req & ~i_have;
    assign dmem_stall = d_req & ~d_have;
    assign advance    = ~imem_stall & ~dmem_stall;

    always_comb begin
        state_d   = state_q;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        m_wmask_d = m_wmask_q;
        i_set     = 1'b0;
        i_cap     = 1'b0;
        d_set     = 1'b0;
        d_cap     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (d_req && !d_have) begin
                    state_d   = D_ACT;
                    m_we_d    = d_we;
                    m_addr_d  = d_addr;
                    m_wdata_d = d_wdata;
                    m_wmask_d = d_wmask;
                end else if (i_req && !i_have && !flush) begin
                    state_d   = I_ACT;
                    m_we_d    = 1'b0;
                    m_addr_d  = i_addr;
                    m_wmask_d = '0;
                end
            end
            I_ACT: begin
                if (m_ready) begin
                    state_d = IDLE;
                    i_set   = ~flush;
                    i_cap   = ~flush;
                end else if (flush) begin
                    state_d = I_DRAIN;
                end
            end
            // A cancelled fetch still runs to completion on the bus.
            I_DRAIN: begin
                if (m_ready) begin
                    state_d = IDLE;
                end
            end
            D_ACT: begin
                if (m_ready) begin
                    state_d = IDLE;
                    d_set   = 1'b1;
                    d_cap   = ~m_we_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_wmask_q <= '0;
        end else begin
            state_q   <= state_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            m_wmask_q <= m_wmask_d;
        end
    end

    assign m_req   = (state_q != IDLE);
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign m_wmask = m_wmask_q;

    mem_port_arbiter_resp_hold #(
        .DATA_W (DATA_W)
    ) u_i_hold (
        .clk    (clk),
        .rst    (rst),
        .i_set  (i_set),
        .i_cap  (i_cap),
        .i_clr  (advance | flush),
        .i_data (m_rdata),
        .o_have (i_have),
        .o_data (i_rdata)
    );

    mem_port_arbiter_resp_hold #(
        .DATA_W (DATA_W)
    ) u_d_hold (
        .clk    (clk),
        .rst    (rst),
        .i_set  (d_set),
        .i_cap  (d_cap),
        .i_clr  (advance),
        .i_data (m_rdata),
        .o_have (d_have),
        .o_data (d_rdata)
    );

endmodule
`default_nettype wire
